ir_regfile_sequencer: RTL and testbench

IR_REGFILE_SEQUENCER -- requirements
Module: ir_regfile_sequencer

---
 rtl/ir_regfile_sequencer_pkg.sv | 35 +++
 rtl/ir_regfile_sequencer_decode.sv | 24 ++
 rtl/ir_regfile_sequencer.sv | 155 +++++++++++++++
 tb/tb_ir_regfile_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ir_regfile_sequencer_pkg.sv
// Shared types and constants for the IR/register-file control sequencer.
package ir_regfile_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5,
        ST_FAULT  = 3'd6
    } seqState_t;

    typedef enum logic [2:0] {
        CLS_ALU  = 3'd0,
        CLS_LW   = 3'd1,
        CLS_SW   = 3'd2,
        CLS_BR   = 3'd3,
        CLS_WCR  = 3'd4,
        CLS_HALT = 3'd5,
        CLS_NOP  = 3'd6
    } opClass_t;

    // 0x0-0x7 are ALU ops; 0xC-0xE are unassigned and run as NOPs.
    localparam logic [3:0] OP_LW   = 4'h8;
    localparam logic [3:0] OP_SW   = 4'h9;
    localparam logic [3:0] OP_BR   = 4'hA;
    localparam logic [3:0] OP_WCR  = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [3:0]  CR_REG_IDX    = 4'h8;
    localparam int unsigned TIMEOUT_LIMIT = 16;
    localparam logic [3:0]  WAIT_CNT_MAX  = 4'(TIMEOUT_LIMIT - 1);

endpackage

// File: rtl/ir_regfile_sequencer_decode.sv
// Combinational opcode-to-class mapping used by the sequencer FSM.
module irseq_decode
    import ir_regfile_sequencer_pkg::*;
(
    input  logic [3:0] opcode,
    output opClass_t   opClass
);

    // Classify the opcode nibble
    always_comb begin
        opClass = CLS_NOP;
        case (opcode)
            4'h0, 4'h1, 4'h2, 4'h3,
            4'h4, 4'h5, 4'h6, 4'h7: opClass = CLS_ALU;
            OP_LW:                  opClass = CLS_LW;
            OP_SW:                  opClass = CLS_SW;
            OP_BR:                  opClass = CLS_BR;
            OP_WCR:                 opClass = CLS_WCR;
            OP_HALT:                opClass = CLS_HALT;
            default:                opClass = CLS_NOP;
        endcase
    end

endmodule

// File: rtl/ir_regfile_sequencer.sv
// Multi-cycle fetch/decode/exec/mem/wb control sequencer for an IR + register file.
// Define IRSEQ_MEM_TIMEOUT_EN to fault after 16 unacknowledged memory request cycles.
module ir_regfile_sequencer
    import ir_regfile_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] instr,
    input  logic        mem_ack,
    input  logic        branch_taken,
    output logic        mem_req,
    output logic        mem_we,
    output logic        writeIR,
    output logic        pc_write,
    output logic        writeRegFile,
    output logic [3:0]  WriteToReg,
    output logic        CRwrite,
    output logic        halted,
    output logic        fault
);

    seqState_t  state_r;
    seqState_t  nextState_s;
    opClass_t   opClass_s;
    logic [3:0] opcode_r;
    logic [3:0] decIn_s;
    logic       memReq_r;
    logic       memWe_r;
    logic       writeRf_r;
    logic [3:0] writeAddr_r;
    logic       crWrite_r;
    logic       halted_r;
    logic       brExec_r;
    logic       ackTaken_s;
    logic       timeout_s;
    logic       unusedInstr_s;

    // DECODE classifies the live IR; later states use the latched opcode.
    assign decIn_s = (state_r == ST_DECODE) ? instr[15:12] : opcode_r;

    irseq_decode uDecode (
        .opcode  (decIn_s),
        .opClass (opClass_s)
    );

    assign ackTaken_s    = memReq_r & mem_ack;
    assign unusedInstr_s = ^instr[11:4];

`ifdef IRSEQ_MEM_TIMEOUT_EN
    logic [3:0] waitCnt_r;
    logic       fault_r;

    // Count consecutive unacknowledged request cycles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            waitCnt_r <= 4'd0;
        end else if (memReq_r && !mem_ack) begin
            waitCnt_r <= waitCnt_r + 4'd1;
        end else begin
            waitCnt_r <= 4'd0;
        end
    end

    // Flag fault state as a registered output
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fault_r <= 1'b0;
        end else begin
            fault_r <= (nextState_s == ST_FAULT);
        end
    end

    assign timeout_s = memReq_r & ~mem_ack & (waitCnt_r == WAIT_CNT_MAX);
    assign fault     = fault_r;
`else
    assign timeout_s = 1'b0;
    assign fault     = 1'b0;
`endif

    // Next-state selection
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            ST_FETCH: begin
                if (ackTaken_s)     nextState_s = ST_DECODE;
                else if (timeout_s) nextState_s = ST_FAULT;
                else                nextState_s = ST_FETCH;
            end
            ST_DECODE: begin
                if (opClass_s == CLS_HALT) nextState_s = ST_HALT;
                else                       nextState_s = ST_EXEC;
            end
            ST_EXEC: begin
                case (opClass_s)
                    CLS_ALU, CLS_WCR: nextState_s = ST_WB;
                    CLS_LW, CLS_SW:   nextState_s = ST_MEM;
                    default:          nextState_s = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                if (ackTaken_s)     nextState_s = (opClass_s == CLS_LW) ? ST_WB : ST_FETCH;
                else if (timeout_s) nextState_s = ST_FAULT;
                else                nextState_s = ST_MEM;
            end
            ST_WB:    nextState_s = ST_FETCH;
            ST_HALT:  nextState_s = ST_HALT;
            ST_FAULT: nextState_s = ST_FAULT;
            default:  nextState_s = ST_FETCH;
        endcase
    end

    // State register with outputs registered from the state being entered
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_FETCH;
            opcode_r    <= 4'h0;
            memReq_r    <= 1'b0;
            memWe_r     <= 1'b0;
            writeRf_r   <= 1'b0;
            writeAddr_r <= 4'h0;
            crWrite_r   <= 1'b0;
            halted_r    <= 1'b0;
            brExec_r    <= 1'b0;
        end else begin
            state_r <= nextState_s;
            if (state_r == ST_DECODE) begin
                opcode_r <= instr[15:12];
            end else begin
                opcode_r <= opcode_r;
            end
            memReq_r  <= (nextState_s == ST_FETCH) || (nextState_s == ST_MEM);
            memWe_r   <= (nextState_s == ST_MEM) && (opClass_s == CLS_SW);
            writeRf_r <= (nextState_s == ST_WB);
            crWrite_r <= (nextState_s == ST_WB) && (opClass_s == CLS_WCR);
            if (nextState_s == ST_WB) begin
                writeAddr_r <= (opClass_s == CLS_WCR) ? CR_REG_IDX : instr[3:0];
            end else begin
                writeAddr_r <= 4'h0;
            end
            halted_r <= (nextState_s == ST_HALT);
            brExec_r <= (nextState_s == ST_EXEC) && (opClass_s == CLS_BR);
        end
    end

    // The IR load and PC bump must respond to mem_ack within the same cycle.
    assign writeIR      = (state_r == ST_FETCH) & ackTaken_s;
    assign pc_write     = writeIR | (brExec_r & branch_taken);
    assign mem_req      = memReq_r;
    assign mem_we       = memWe_r;
    assign writeRegFile = writeRf_r;
    assign WriteToReg   = writeAddr_r;
    assign CRwrite      = crWrite_r;
    assign halted       = halted_r;

endmodule

// File: tb/tb_ir_regfile_sequencer.sv
// Scoreboard bench for ir_regfile_sequencer: per-cycle expected output vectors.
module tb_ir_regfile_sequencer;

    logic        clk;
    logic        rst_n;
    logic [15:0] instr;
    logic        mem_ack;
    logic        branch_taken;
    logic        mem_req;
    logic        mem_we;
    logic        writeIR;
    logic        pc_write;
    logic        writeRegFile;
    logic [3:0]  WriteToReg;
    logic        CRwrite;
    logic        halted;
    logic        fault;

    // Vector layout: {mem_req, mem_we, writeIR, pc_write, writeRegFile, WriteToReg[3:0], CRwrite, halted, fault}
    logic [11:0] obsVec;
    assign obsVec = {mem_req, mem_we, writeIR, pc_write, writeRegFile, WriteToReg, CRwrite, halted, fault};

    localparam logic [11:0] NONE       = 12'h000;
    localparam logic [11:0] FETCH_WAIT = 12'h800;
    localparam logic [11:0] FETCH_ACK  = 12'hB00;

    typedef struct packed {
        logic [15:0] ins;
        logic        ack;
        logic        bt;
        logic        rstn;
        logic [11:0] exp;
    } row_t;

    logic [11:0] expQ[$];
    int compared   = 0;
    int mismatched = 0;

    ir_regfile_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr        (instr),
        .mem_ack      (mem_ack),
        .branch_taken (branch_taken),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .writeIR      (writeIR),
        .pc_write     (pc_write),
        .writeRegFile (writeRegFile),
        .WriteToReg   (WriteToReg),
        .CRwrite      (CRwrite),
        .halted       (halted),
        .fault        (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] ov(input logic req, input logic we, input logic ir, input logic pc,
                                       input logic rf, input logic [3:0] wtr, input logic cr,
                                       input logic hlt, input logic flt);
        return {req, we, ir, pc, rf, wtr, cr, hlt, flt};
    endfunction

    function automatic row_t r(input logic [15:0] ins, input logic ack, input logic bt,
                               input logic rstn, input logic [11:0] e);
        row_t x;
        x.ins = ins; x.ack = ack; x.bt = bt; x.rstn = rstn; x.exp = e;
        return x;
    endfunction

    // Drive one cycle's inputs just after the edge, record its expectation, return at the sample point.
    task automatic drive(input row_t rw);
        @(posedge clk); #1;
        instr        = rw.ins;
        mem_ack      = rw.ack;
        branch_taken = rw.bt;
        rst_n        = rw.rstn;
        expQ.push_back(rw.exp);
        #3;
    endtask

    // Reset, release, and return at the end of the all-zero release cycle.
    task automatic doReset(input logic [15:0] ins);
        @(posedge clk); #1;
        rst_n = 1'b0; mem_ack = 1'b0; branch_taken = 1'b0; instr = ins;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #3;
    endtask

    task automatic test_reset();
        row_t rows[$];
        logic [11:0] want;
        rows.push_back(r(16'h1234, 1'b1, 1'b1, 1'b0, NONE));
        rows.push_back(r(16'h1234, 1'b1, 1'b1, 1'b0, NONE));
        rows.push_back(r(16'h1234, 1'b1, 1'b0, 1'b1, NONE));
        rows.push_back(r(16'h1234, 1'b0, 1'b0, 1'b1, FETCH_WAIT));
        rows.push_back(r(16'h1234, 1'b1, 1'b0, 1'b1, FETCH_ACK));
        rows.push_back(r(16'h1234, 1'b0, 1'b0, 1'b1, NONE));
        foreach (rows[i]) begin
            drive(rows[i]);
            want = expQ.pop_front();
            compared++;
            if (obsVec !== want) begin
                mismatched++;
                $display("FAIL reset cycle %0d: got %03h expected %03h", i, obsVec, want);
            end
        end
    endtask

    task automatic test_alu();
        row_t rows[$];
        logic [11:0] want;
        doReset(16'h1234);
        rows.push_back(r(16'h1234, 1'b1, 1'b0, 1'b1, FETCH_ACK));
        rows.push_back(r(16'h1234, 1'b1, 1'b0, 1'b1, NONE));
        rows.push_back(r(16'h1234, 1'b1, 1'b0, 1'b1, NONE));
        rows.push_back(r(16'h1234, 1'b1, 1'b0, 1'b1, ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h4, 1'b0, 1'b0, 1'b0)));
        rows.push_back(r(16'h1234, 1'b1, 1'b0, 1'b1, FETCH_ACK));
        foreach (rows[i]) begin
            drive(rows[i]);
            want = expQ.pop_front();
            compared++;
            if (obsVec !== want) begin
                mismatched++;
                $display("FAIL alu cycle %0d: got %03h expected %03h", i + 1, obsVec, want);
            end
        end
    endtask

    task automatic test_lw();
        row_t rows[$];
        logic [11:0] want;
        logic [11:0] memRd;
        memRd = ov(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        doReset(16'h8005);
        rows.push_back(r(16'h8005, 1'b0, 1'b0, 1'b1, FETCH_WAIT));
        rows.push_back(r(16'h8005, 1'b1, 1'b0, 1'b1, FETCH_ACK));
        rows.push_back(r(16'h8005, 1'b1, 1'b0, 1'b1, NONE));
        rows.push_back(r(16'h8005, 1'b1, 1'b0, 1'b1, NONE));
        for (int k = 0; k < 3; k++) rows.push_back(r(16'h8005, 1'b0, 1'b0, 1'b1, memRd));
        rows.push_back(r(16'h8005, 1'b1, 1'b0, 1'b1, memRd));
        rows.push_back(r(16'h8005, 1'b1, 1'b0, 1'b1, ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0)));
        rows.push_back(r(16'h8005, 1'b1, 1'b0, 1'b1, FETCH_ACK));
        foreach (rows[i]) begin
            drive(rows[i]);
            want = expQ.pop_front();
            compared++;
            if (obsVec !== want) begin
                mismatched++;
                $display("FAIL lw cycle %0d: got %03h expected %03h", i + 1, obsVec, want);
            end
        end
    endtask

    task automatic test_wcr();
        row_t rows[$];
        logic [11:0] want;
        doReset(16'hB000);
        rows.push_back(r(16'hB000, 1'b1, 1'b0, 1'b1, FETCH_ACK));
        rows.push_back(r(16'hB000, 1'b1, 1'b0, 1'b1, NONE));
        rows.push_back(r(16'hB000, 1'b1, 1'b0, 1'b1, NONE));
        rows.push_back(r(16'hB000, 1'b1, 1'b0, 1'b1, ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h8, 1'b1, 1'b0, 1'b0)));
        rows.push_back(r(16'hB000, 1'b1, 1'b0, 1'b1, FETCH_ACK));
        foreach (rows[i]) begin
            drive(rows[i]);
            want = expQ.pop_front();
            compared++;
            if (obsVec !== want) begin
                mismatched++;
                $display("FAIL wcr cycle %0d: got %03h expected %03h", i + 1, obsVec, want);
            end
        end
    endtask

    task automatic test_branch();
        row_t rows[$];
        logic [11:0] want;
        doReset(16'hA000);
        rows.push_back(r(16'hA000, 1'b1, 1'b1, 1'b1, FETCH_ACK));
        rows.push_back(r(16'hA000, 1'b1, 1'b1, 1'b1, NONE));
        rows.push_back(r(16'hA000, 1'b1, 1'b1, 1'b1, ov(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0)));
        rows.push_back(r(16'hA000, 1'b1, 1'b0, 1'b1, FETCH_ACK));
        rows.push_back(r(16'hA000, 1'b1, 1'b1, 1'b1, NONE));
        rows.push_back(r(16'hA000, 1'b1, 1'b0, 1'b1, NONE));
        rows.push_back(r(16'hA000, 1'b1, 1'b0, 1'b1, FETCH_ACK));
        foreach (rows[i]) begin
            drive(rows[i]);
            want = expQ.pop_front();
            compared++;
            if (obsVec !== want) begin
                mismatched++;
                $display("FAIL branch cycle %0d: got %03h expected %03h", i + 1, obsVec, want);
            end
        end
    endtask

    task automatic test_sw_reset();
        row_t rows[$];
        logic [11:0] want;
        logic [11:0] memWr;
        memWr = ov(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        doReset(16'h9000);
        rows.push_back(r(16'h9000, 1'b1, 1'b0, 1'b1, FETCH_ACK));
        rows.push_back(r(16'h9000, 1'b0, 1'b0, 1'b1, NONE));
        rows.push_back(r(16'h9000, 1'b0, 1'b0, 1'b1, NONE));
        rows.push_back(r(16'h9000, 1'b1, 1'b0, 1'b1, memWr));
        rows.push_back(r(16'h9000, 1'b1, 1'b0, 1'b1, FETCH_ACK));
        rows.push_back(r(16'h9000, 1'b0, 1'b0, 1'b1, NONE));
        rows.push_back(r(16'h9000, 1'b0, 1'b0, 1'b1, NONE));
        rows.push_back(r(16'h9000, 1'b0, 1'b0, 1'b1, memWr));
        rows.push_back(r(16'h9000, 1'b0, 1'b0, 1'b0, memWr));
        rows.push_back(r(16'h9000, 1'b0, 1'b0, 1'b0, NONE));
        rows.push_back(r(16'h9000, 1'b1, 1'b0, 1'b0, NONE));
        rows.push_back(r(16'h9000, 1'b1, 1'b0, 1'b1, NONE));
        rows.push_back(r(16'h9000, 1'b1, 1'b0, 1'b1, FETCH_ACK));
        foreach (rows[i]) begin
            drive(rows[i]);
            want = expQ.pop_front();
            compared++;
            if (obsVec !== want) begin
                mismatched++;
                $display("FAIL sw_reset cycle %0d: got %03h expected %03h", i + 1, obsVec, want);
            end
        end
    endtask

    task automatic test_illegal_halt();
        row_t rows[$];
        logic [11:0] want;
        logic [11:0] hlt;
        hlt = ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        doReset(16'hC000);
        rows.push_back(r(16'hC000, 1'b1, 1'b0, 1'b1, FETCH_ACK));
        rows.push_back(r(16'hC000, 1'b1, 1'b0, 1'b1, NONE));
        rows.push_back(r(16'hC000, 1'b1, 1'b0, 1'b1, NONE));
        rows.push_back(r(16'hC000, 1'b1, 1'b0, 1'b1, FETCH_ACK));
        rows.push_back(r(16'hF000, 1'b1, 1'b0, 1'b1, NONE));
        rows.push_back(r(16'hF000, 1'b1, 1'b1, 1'b1, hlt));
        rows.push_back(r(16'hF000, 1'b1, 1'b1, 1'b1, hlt));
        rows.push_back(r(16'hF000, 1'b0, 1'b0, 1'b1, hlt));
        foreach (rows[i]) begin
            drive(rows[i]);
            want = expQ.pop_front();
            compared++;
            if (obsVec !== want) begin
                mismatched++;
                $display("FAIL illegal_halt cycle %0d: got %03h expected %03h", i + 1, obsVec, want);
            end
        end
    endtask

    task automatic test_timeout();
        row_t rows[$];
        logic [11:0] want;
        logic [11:0] flt;
        flt = ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        doReset(16'h1234);
        for (int k = 0; k < 20; k++) begin
`ifdef IRSEQ_MEM_TIMEOUT_EN
            rows.push_back(r(16'h1234, 1'b0, 1'b0, 1'b1, (k < 16) ? FETCH_WAIT : flt));
`else
            rows.push_back(r(16'h1234, 1'b0, 1'b0, 1'b1, FETCH_WAIT));
`endif
        end
`ifdef IRSEQ_MEM_TIMEOUT_EN
        rows.push_back(r(16'h1234, 1'b1, 1'b0, 1'b1, flt));
`else
        rows.push_back(r(16'h1234, 1'b1, 1'b0, 1'b1, FETCH_ACK));
`endif
        foreach (rows[i]) begin
            drive(rows[i]);
            want = expQ.pop_front();
            compared++;
            if (obsVec !== want) begin
                mismatched++;
                $display("FAIL timeout cycle %0d: got %03h expected %03h", i + 1, obsVec, want);
            end
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        instr        = 16'h1234;
        mem_ack      = 1'b0;
        branch_taken = 1'b0;
        test_reset();
        test_alu();
        test_lw();
        test_wcr();
        test_branch();
        test_sw_reset();
        test_illegal_halt();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
